// File: rtl/ptmch_trg_log.sv
// Trigger event logger: rising-edge detect on the stretched trigger bus, timestamp
// against a free-running counter, and queue {evt, ts} in a show-ahead FIFO.
module ptmch_trg_log #(
  parameter int TS_W  = 24,
  parameter int DEPTH = 16
) (
  input  logic                   CLK160M,
  input  logic                   RESET_N,
  input  logic [4:0]             TRG_PLS,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic                   RD_READY,
  output logic                   RD_VALID,
  output logic [TS_W+4:0]        RD_DATA,
  output logic [$clog2(DEPTH):0] FIFO_LVL,
  output logic                   OVF,
  output logic [15:0]            DROP_CNT,
  output logic [TS_W-1:0]        TS_NOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] LVL_FULL = LW'(DEPTH);

  logic [TS_W-1:0] r_ts;
  logic [4:0]      r_trg_1d;
  logic [4:0]      r_trg_2d;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_lvl;
  logic            r_ovf;
  logic [15:0]     r_drop;
  logic [TS_W+4:0] r_mem [DEPTH];

  logic [4:0] w_evt;
  logic       w_push;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;
  logic       w_drop;

  assign w_evt  = r_trg_1d & ~r_trg_2d;
  assign w_push = (|w_evt) & EN;
  assign w_full = (r_lvl == LVL_FULL);
  // CLR wins over both ports; a pop frees the slot a full-FIFO push needs.
  assign w_pop  = RD_VALID & RD_READY & ~CLR;
  assign w_wr   = w_push & ~CLR & (~w_full | w_pop);
  assign w_drop = w_push & ~CLR & w_full & ~w_pop;

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ts     <= '0;
      r_trg_1d <= '0;
      r_trg_2d <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lvl    <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      // Edge history survives CLR so a pulse spanning it is not logged twice.
      r_trg_1d <= TRG_PLS;
      r_trg_2d <= r_trg_1d;
      if (CLR) begin
        r_ts     <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_lvl    <= '0;
        r_ovf    <= 1'b0;
        r_drop   <= '0;
      end else begin
        r_ts <= r_ts + 1'b1;
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_wr && !w_pop) begin
          r_lvl <= r_lvl + 1'b1;
        end else if (!w_wr && w_pop) begin
          r_lvl <= r_lvl - 1'b1;
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK160M) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_evt, r_ts};
    end
  end

  assign RD_VALID = (r_lvl != '0);
  assign RD_DATA  = RD_VALID ? r_mem[r_rd_ptr] : '0;
  assign FIFO_LVL = r_lvl;
  assign OVF      = r_ovf;
  assign DROP_CNT = r_drop;
  assign TS_NOW   = r_ts;

endmodule

// File: tb/tb_ptmch_trg_log.sv
// Bench for ptmch_trg_log: directed scenarios plus randomized traffic against a
// queue-based model; a second 8-bit-timestamp instance covers counter wrap.
module tb_ptmch_trg_log;

  localparam int TS_W  = 24;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      trg;
  logic            en;
  logic            clr;
  logic            rdy;
  logic            rd_valid;
  logic [TS_W+4:0] rd_data;
  logic [4:0]      lvl;
  logic            ovf;
  logic [15:0]     drop;
  logic [TS_W-1:0] ts_now;

  logic [4:0]  trg8;
  logic        en8;
  logic        clr8;
  logic        rdy8;
  logic        rd_valid8;
  logic [12:0] rd_data8;
  logic [4:0]  lvl8;
  logic        ovf8;
  logic [15:0] drop8;
  logic [7:0]  ts8;

  int checks   = 0;
  int failures = 0;

  logic [4:0]      m_s1;
  logic [4:0]      m_s2;
  logic [TS_W-1:0] m_ts;
  logic [TS_W+4:0] m_q[$];
  logic            m_ovf;
  logic [15:0]     m_drop;

  always #5 clk = ~clk;

  ptmch_trg_log #(.TS_W(TS_W), .DEPTH(DEPTH)) u_dut (
    .CLK160M(clk), .RESET_N(rst_n), .TRG_PLS(trg), .EN(en), .CLR(clr),
    .RD_READY(rdy), .RD_VALID(rd_valid), .RD_DATA(rd_data), .FIFO_LVL(lvl),
    .OVF(ovf), .DROP_CNT(drop), .TS_NOW(ts_now)
  );

  ptmch_trg_log #(.TS_W(8), .DEPTH(DEPTH)) u_dut8 (
    .CLK160M(clk), .RESET_N(rst_n), .TRG_PLS(trg8), .EN(en8), .CLR(clr8),
    .RD_READY(rdy8), .RD_VALID(rd_valid8), .RD_DATA(rd_data8), .FIFO_LVL(lvl8),
    .OVF(ovf8), .DROP_CNT(drop8), .TS_NOW(ts8)
  );

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_ts = '0; m_ovf = 1'b0; m_drop = '0;
    m_q.delete();
  endtask

  function automatic logic [TS_W+4:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  // Apply one cycle of inputs (called at negedge), advance the model over the edge.
  task automatic step(input logic [4:0] t, input logic e, input logic c, input logic r);
    logic [4:0] evt;
    bit push, pop;
    trg = t; en = e; clr = c; rdy = r;
    @(posedge clk);
    evt  = m_s1 & ~m_s2;
    push = (evt != 5'd0) && e;
    pop  = (m_q.size() > 0) && r;
    if (c) begin
      m_q.delete(); m_ovf = 1'b0; m_drop = '0; m_ts = '0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back({evt, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
      m_ts = m_ts + 24'd1;
    end
    m_s2 = m_s1;
    m_s1 = t;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trg = '0; en = 1'b1; clr = 1'b0; rdy = 1'b0;
    trg8 = '0; en8 = 1'b1; clr8 = 1'b0; rdy8 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rd_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    checks++; if (lvl !== 5'd0) begin failures++; $display("FAIL reset_lvl got=%0d exp=0", lvl); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (drop !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop); end
    checks++; if (ts_now !== '0) begin failures++; $display("FAIL reset_ts got=%0d exp=0", ts_now); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    for (int i = 0; i < 200 && m_ts != 24'd100; i++) step(5'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (ts_now !== 24'd100) begin failures++; $display("FAIL single_ts got=%0d exp=100", ts_now); end
    step(5'b00001, 1'b1, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b exp=0", rd_valid); end
    step(5'b00001, 1'b1, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", rd_valid); end
    checks++; if (rd_data !== {5'b00001, 24'd101}) begin failures++; $display("FAIL single_data got=%h exp=%h", rd_data, {5'b00001, 24'd101}); end
    repeat (14) step(5'b00001, 1'b1, 1'b0, 1'b0);
    repeat (2) step(5'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (lvl !== 5'd1) begin failures++; $display("FAIL single_lvl got=%0d exp=1", lvl); end
    step(5'd0, 1'b1, 1'b0, 1'b1);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%0b exp=0", rd_valid); end
    $display("test_single done");
  endtask

  task automatic test_simultaneous();
    repeat (3) step(5'b10100, 1'b1, 1'b0, 1'b0);
    repeat (2) step(5'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (lvl !== 5'd1) begin failures++; $display("FAIL simul_lvl got=%0d exp=1", lvl); end
    checks++; if (rd_data[28:24] !== 5'b10100) begin failures++; $display("FAIL simul_evt got=%b exp=10100", rd_data[28:24]); end
    step(5'd0, 1'b1, 1'b0, 1'b1);
    $display("test_simultaneous done");
  endtask

  task automatic test_overflow();
    logic [4:0] b;
    logic [23:0] prev_ts;
    for (int i = 0; i < 20; i++) begin
      b = 5'd1 << $urandom_range(0, 4);
      step(b, 1'b1, 1'b0, 1'b0);
      step(5'd0, 1'b1, 1'b0, 1'b0);
    end
    step(5'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (lvl !== 5'd16) begin failures++; $display("FAIL ovf_lvl got=%0d exp=16", lvl); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
    checks++; if (drop !== 16'd4) begin failures++; $display("FAIL ovf_drop got=%0d exp=4", drop); end
    prev_ts = '0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== exp_head()) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd_data, exp_head()); end
      if (i > 0) begin
        checks++; if (rd_data[23:0] <= prev_ts) begin failures++; $display("FAIL ovf_order%0d got=%0d exp>%0d", i, rd_data[23:0], prev_ts); end
      end
      prev_ts = rd_data[23:0];
      step(5'd0, 1'b1, 1'b0, 1'b1);
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0b exp=0", rd_valid); end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    logic [23:0] exp_ts;
    for (int i = 0; i < 16; i++) begin
      step(5'b01000, 1'b1, 1'b0, 1'b0);
      step(5'd0, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (lvl !== 5'd16) begin failures++; $display("FAIL full_fill_lvl got=%0d exp=16", lvl); end
    step(5'b00010, 1'b1, 1'b0, 1'b0);
    exp_ts = m_ts;
    step(5'd0, 1'b1, 1'b0, 1'b1);
    checks++; if (lvl !== 5'd16) begin failures++; $display("FAIL full_pp_lvl got=%0d exp=16", lvl); end
    checks++; if (drop !== 16'd4) begin failures++; $display("FAIL full_pp_drop got=%0d exp=4", drop); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== exp_head()) begin failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, rd_data, exp_head()); end
      if (i == 15) begin
        checks++; if (rd_data !== {5'b00010, exp_ts}) begin failures++; $display("FAIL full_last got=%h exp=%h", rd_data, {5'b00010, exp_ts}); end
      end
      step(5'd0, 1'b1, 1'b0, 1'b1);
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_en_clr();
    repeat (3) step(5'b00001, 1'b0, 1'b0, 1'b0);
    repeat (2) step(5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (lvl !== 5'd0) begin failures++; $display("FAIL en_gate_lvl got=%0d exp=0", lvl); end
    for (int i = 0; i < 5; i++) begin
      step(5'b00100, 1'b1, 1'b0, 1'b0);
      step(5'd0, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (lvl !== 5'd5) begin failures++; $display("FAIL clr_pre_lvl got=%0d exp=5", lvl); end
    step(5'b00001, 1'b1, 1'b0, 1'b0);
    step(5'b00001, 1'b1, 1'b1, 1'b0);
    checks++; if (lvl !== 5'd0) begin failures++; $display("FAIL clr_lvl got=%0d exp=0", lvl); end
    checks++; if (ts_now !== '0) begin failures++; $display("FAIL clr_ts got=%0d exp=0", ts_now); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%0b exp=0", ovf); end
    checks++; if (drop !== 16'd0) begin failures++; $display("FAIL clr_drop got=%0d exp=0", drop); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%0b exp=0", rd_valid); end
    repeat (2) step(5'b00001, 1'b1, 1'b0, 1'b0);
    repeat (2) step(5'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (lvl !== 5'd0) begin failures++; $display("FAIL clr_relog_lvl got=%0d exp=0", lvl); end
    $display("test_en_clr done");
  endtask

  task automatic test_random();
    logic [4:0] t;
    logic e, c, r;
    t = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) t = 5'($urandom);
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 79) == 0);
      r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      step(t, e, c, r);
      checks++; if (rd_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_valid%0d got=%0b exp=%0b", i, rd_valid, m_q.size() > 0); end
      checks++; if (rd_data !== exp_head()) begin failures++; $display("FAIL rnd_data%0d got=%h exp=%h", i, rd_data, exp_head()); end
      checks++; if (lvl !== 5'(m_q.size())) begin failures++; $display("FAIL rnd_lvl%0d got=%0d exp=%0d", i, lvl, m_q.size()); end
      checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf%0d got=%0b exp=%0b", i, ovf, m_ovf); end
      checks++; if (drop !== m_drop) begin failures++; $display("FAIL rnd_drop%0d got=%0d exp=%0d", i, drop, m_drop); end
      checks++; if (ts_now !== m_ts) begin failures++; $display("FAIL rnd_ts%0d got=%0d exp=%0d", i, ts_now, m_ts); end
    end
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      step(5'b10000, 1'b1, 1'b0, 1'b0);
      step(5'd0, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (lvl === 5'd0) begin failures++; $display("FAIL areset_pre_lvl got=%0d exp=nonzero", lvl); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", rd_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL areset_data got=%h exp=0", rd_data); end
    checks++; if (lvl !== 5'd0) begin failures++; $display("FAIL areset_lvl got=%0d exp=0", lvl); end
    checks++; if (ts_now !== '0) begin failures++; $display("FAIL areset_ts got=%0d exp=0", ts_now); end
    checks++; if (ovf !== 1'b0 || drop !== 16'd0) begin failures++; $display("FAIL areset_ovf got=%0b/%0d exp=0/0", ovf, drop); end
    trg = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_async_reset done");
  endtask

  task automatic test_wrap();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (ts8 == 8'd255) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL wrap_timeout got=%0d exp=255", ts8); end
    trg8 = 5'b00001;
    @(negedge clk);
    checks++; if (ts8 !== 8'd0) begin failures++; $display("FAIL wrap_ts got=%0d exp=0", ts8); end
    @(negedge clk);
    trg8 = '0;
    checks++; if (rd_valid8 !== 1'b1 || lvl8 !== 5'd1) begin failures++; $display("FAIL wrap_valid got=%0b/%0d exp=1/1", rd_valid8, lvl8); end
    checks++; if (rd_data8 !== {5'b00001, 8'd0}) begin failures++; $display("FAIL wrap_data got=%h exp=%h", rd_data8, {5'b00001, 8'd0}); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_en_clr();
    test_random();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
